// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
//   Groups the instruction-memory handshake and the execution-unit control
//   signals of the core sequencer.
//
//   Signals:
//     imem_req     sequencer -> memory  instruction fetch request
//     imem_addr    sequencer -> memory  fetch address (equals pc)
//     imem_ack     memory -> sequencer  fetch complete, imem_data valid
//     imem_data    memory -> sequencer  fetched instruction word
//     instruction  sequencer -> units   instruction register broadcast
//     alu_reg_en_n sequencer -> units   active-low enable, R-type unit
//     alu_imm_en_n sequencer -> units   active-low enable, I-type unit
//     rf_we        sequencer -> RF      register-file write strobe
//     pc           sequencer -> out     program counter
//     instret      sequencer -> out     retired-instruction counter
//     illegal      sequencer -> out     sticky unsupported-opcode flag
//
//   Modports: master = sequencer side, slave = memory / execution side.
// -----------------------------------------------------------------------------
interface core_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_data;
   logic [XLEN-1:0] instruction;
   logic            alu_reg_en_n;
   logic            alu_imm_en_n;
   logic            rf_we;
   logic [XLEN-1:0] pc;
   logic [31:0]     instret;
   logic            illegal;

   modport master (
      output imem_req, imem_addr, instruction, alu_reg_en_n, alu_imm_en_n,
             rf_we, pc, instret, illegal,
      input  imem_ack, imem_data
   );

   modport slave (
      input  imem_req, imem_addr, instruction, alu_reg_en_n, alu_imm_en_n,
             rf_we, pc, instret, illegal,
      output imem_ack, imem_data
   );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the integer core. Fetches one instruction at a
//   time over a req/ack handshake into the instruction register, decodes the
//   opcode, drives the active-low enable of the R-type or I-type ALU unit for
//   two cycles, strobes register-file writeback and advances pc / instret.
//   Unsupported opcodes park the FSM in TRAP with the sticky illegal flag set.
//
//   Ports:
//     clk    core clock, rising-edge active
//     rst_n  asynchronous active-low reset
//     bus    core_sequencer_if.master (fetch handshake, IR, unit enables,
//            rf_we, pc, instret, illegal)
// -----------------------------------------------------------------------------
module core_sequencer #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   core_sequencer_if.master  bus
);

   localparam logic [6:0] OPC_REG = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_A,
      S_EXEC_B,
      S_TRAP
   } state_e;

   state_e          state_q,   state_d;
   logic [XLEN-1:0] pc_q,      pc_d;
   logic [XLEN-1:0] ir_q,      ir_d;
   logic [31:0]     instret_q, instret_d;
   logic            illegal_q, illegal_d;
   logic            sel_imm_q, sel_imm_d;

   logic            imem_req;
   logic            reg_en_n;
   logic            imm_en_n;
   logic            rf_we;

   // State register. Reset acts immediately so all decoded outputs return to
   // their idle values without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         sel_imm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
         sel_imm_q <= sel_imm_d;
      end
   end

   // Next-state logic. imem_ack is only looked at in FETCH, so stray acks in
   // any other state cannot disturb the IR.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      instret_d = instret_q;
      illegal_d = illegal_q;
      sel_imm_d = sel_imm_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (ir_q[6:0] == OPC_REG) begin
               sel_imm_d = 1'b0;
               state_d   = S_EXEC_A;
            end else if (ir_q[6:0] == OPC_IMM) begin
               sel_imm_d = 1'b1;
               state_d   = S_EXEC_A;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_EXEC_A: begin
            state_d = S_EXEC_B;
         end
         S_EXEC_B: begin
            // Both counters wrap naturally at their register width.
            pc_d      = pc_q + XLEN'(4);
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode, purely from registered state: no path from imem_ack.
   always_comb begin
      imem_req = 1'b0;
      reg_en_n = 1'b1;
      imm_en_n = 1'b1;
      rf_we    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
         end
         S_EXEC_A: begin
            reg_en_n = sel_imm_q;
            imm_en_n = ~sel_imm_q;
         end
         S_EXEC_B: begin
            reg_en_n = sel_imm_q;
            imm_en_n = ~sel_imm_q;
            // Writes to x0 are suppressed.
            rf_we    = (ir_q[11:7] != 5'd0);
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign bus.imem_req     = imem_req;
   assign bus.imem_addr    = pc_q;
   assign bus.instruction  = ir_q;
   assign bus.alu_reg_en_n = reg_en_n;
   assign bus.alu_imm_en_n = imm_en_n;
   assign bus.rf_we        = rf_we;
   assign bus.pc           = pc_q;
   assign bus.instret      = instret_q;
   assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rstw_n = 1'b0;

   int checks = 0;
   int errors = 0;

   core_sequencer_if #(.XLEN(32)) bus ();
   core_sequencer_if #(.XLEN(32)) busw ();

   core_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   core_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk   (clk),
      .rst_n (rstw_n),
      .bus   (busw)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      int          waits;
      logic        exp_imm;
      logic        exp_we;
   } vec_t;

   typedef struct {
      logic        exp_imm;
      logic        exp_we;
      logic [31:0] exp_pc;
      logic [31:0] exp_instret;
   } sb_t;

   vec_t        vecs [5];
   sb_t         sb_q [$];
   sb_t         sb_e;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   int reg_run = 0;
   int imm_run = 0;
   int we_cnt  = 0;
   int we_bad  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: measures each enable window and pops the expected
   // record when the window closes (first cycle after EXEC_B).
   always @(negedge clk) begin
      if (!rst_n) begin
         reg_run = 0;
         imm_run = 0;
         we_cnt  = 0;
         we_bad  = 0;
      end else begin
         chk("en_both_low", {31'd0, ~bus.alu_reg_en_n & ~bus.alu_imm_en_n}, 32'd0);
         if (!bus.alu_reg_en_n) reg_run++;
         if (!bus.alu_imm_en_n) imm_run++;
         if (bus.rf_we) begin
            we_cnt++;
            if (reg_run + imm_run != 2) we_bad++;
         end
         if (bus.alu_reg_en_n && bus.alu_imm_en_n && (reg_run + imm_run) > 0) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               sb_e = sb_q.pop_front();
               chk("sb_reg_run", reg_run, sb_e.exp_imm ? 32'd0 : 32'd2);
               chk("sb_imm_run", imm_run, sb_e.exp_imm ? 32'd2 : 32'd0);
               chk("sb_we_cnt",  we_cnt, {31'd0, sb_e.exp_we});
               chk("sb_we_pos",  we_bad, 32'd0);
               chk("sb_pc",      bus.pc, sb_e.exp_pc);
               chk("sb_instret", bus.instret, sb_e.exp_instret);
            end
            reg_run = 0;
            imm_run = 0;
            we_cnt  = 0;
            we_bad  = 0;
         end
      end
   end

   task automatic release_dut();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("first_addr", bus.imem_addr, 32'h0000_0100);
   endtask

   // Entered at a negedge in FETCH; leaves at the negedge of the next FETCH.
   task automatic run_vec(input vec_t v);
      int cyc;
      cyc = 0;
      chk("fetch_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("fetch_addr", bus.imem_addr, m_pc);
      for (int w = 0; w < v.waits; w++) begin
         bus.imem_ack  = 1'b0;
         bus.imem_data = $urandom;
         @(negedge clk);
         cyc++;
         chk("wait_req",  {31'd0, bus.imem_req}, 32'd1);
         chk("wait_addr", bus.imem_addr, m_pc);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = v.instr;
      sb_q.push_back('{v.exp_imm, v.exp_we, m_pc + 32'd4, m_instret + 32'd1});
      @(negedge clk);
      cyc++;
      chk("ir_load",    bus.instruction, v.instr);
      chk("decode_req", {31'd0, bus.imem_req}, 32'd0);
      // Stray acks while executing must not touch the IR.
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'hDEAD_BEEF;
      m_pc      = m_pc + 32'd4;
      m_instret = m_instret + 32'd1;
      while (cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (bus.imem_req) break;
      end
      bus.imem_ack = 1'b0;
      chk("req_period", cyc, v.waits + 4);
      chk("ir_hold",    bus.instruction, v.instr);
      chk("next_addr",  bus.imem_addr, m_pc);
      chk("instret",    bus.instret, m_instret);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0020_81B3, 0, 1'b0, 1'b1};   // add  x3,x1,x2
      vecs[1] = '{32'h0070_0293, 3, 1'b1, 1'b1};   // addi x5,x0,7
      vecs[2] = '{32'h0020_8033, 0, 1'b0, 1'b0};   // add  x0,x1,x2
      vecs[3] = '{32'h0010_0013, 1, 1'b1, 1'b0};   // addi x0,x0,1
      vecs[4] = '{32'h4020_83B3, 2, 1'b0, 1'b1};   // sub  x7,x1,x2

      bus.imem_ack   = 1'b0;
      bus.imem_data  = '0;
      busw.imem_ack  = 1'b0;
      busw.imem_data = '0;

      // Reset state
      @(negedge clk);
      chk("rst_req",     {31'd0, bus.imem_req}, 32'd0);
      chk("rst_addr",    bus.imem_addr, 32'h0000_0100);
      chk("rst_pc",      bus.pc, 32'h0000_0100);
      chk("rst_ir",      bus.instruction, 32'd0);
      chk("rst_reg_en",  {31'd0, bus.alu_reg_en_n}, 32'd1);
      chk("rst_imm_en",  {31'd0, bus.alu_imm_en_n}, 32'd1);
      chk("rst_we",      {31'd0, bus.rf_we}, 32'd0);
      chk("rst_instret", bus.instret, 32'd0);
      chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);

      release_dut();
      m_pc      = 32'h0000_0100;
      m_instret = 32'd0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Unsupported opcode -> TRAP
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h0000_2003;
      @(negedge clk);
      chk("ill_ir",        bus.instruction, 32'h0000_2003);
      chk("ill_in_decode", {31'd0, bus.illegal}, 32'd0);
      @(negedge clk);
      chk("ill_set", {31'd0, bus.illegal}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("trap_req",     {31'd0, bus.imem_req}, 32'd0);
         chk("trap_reg_en",  {31'd0, bus.alu_reg_en_n}, 32'd1);
         chk("trap_imm_en",  {31'd0, bus.alu_imm_en_n}, 32'd1);
         chk("trap_we",      {31'd0, bus.rf_we}, 32'd0);
         chk("trap_pc",      bus.pc, m_pc);
         chk("trap_instret", bus.instret, m_instret);
         chk("trap_illegal", {31'd0, bus.illegal}, 32'd1);
      end
      bus.imem_ack = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ill_clear",    {31'd0, bus.illegal}, 32'd0);
      chk("ill_rst_pc",   bus.pc, 32'h0000_0100);
      chk("ill_rst_iret", bus.instret, 32'd0);
      @(negedge clk);
      release_dut();
      m_pc      = 32'h0000_0100;
      m_instret = 32'd0;

      // Asynchronous reset during EXEC_B
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h0020_81B3;
      sb_q.push_back('{1'b0, 1'b1, 32'h0000_0104, 32'd1});
      @(negedge clk);
      bus.imem_ack = 1'b0;
      @(negedge clk);
      chk("xa_reg_en", {31'd0, bus.alu_reg_en_n}, 32'd0);
      @(negedge clk);
      chk("xb_we", {31'd0, bus.rf_we}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_we",      {31'd0, bus.rf_we}, 32'd0);
      chk("arst_reg_en",  {31'd0, bus.alu_reg_en_n}, 32'd1);
      chk("arst_imm_en",  {31'd0, bus.alu_imm_en_n}, 32'd1);
      chk("arst_instret", bus.instret, 32'd0);
      chk("arst_pc",      bus.pc, 32'h0000_0100);
      chk("arst_req",     {31'd0, bus.imem_req}, 32'd0);
      sb_q.delete();
      // A late ack during reset and IDLE must be ignored.
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'hCAFE_F00D;
      @(negedge clk);
      release_dut();
      chk("ir_after_rst", bus.instruction, 32'd0);
      m_pc      = 32'h0000_0100;
      m_instret = 32'd0;
      run_vec(vecs[0]);

      // pc wrap with RESET_PC = 32'hFFFF_FFFC
      @(posedge clk);
      #1 rstw_n = 1'b1;
      for (int n = 0; n < 10 && !busw.imem_req; n++) @(negedge clk);
      chk("wrap_req0",  {31'd0, busw.imem_req}, 32'd1);
      chk("wrap_addr0", busw.imem_addr, 32'hFFFF_FFFC);
      busw.imem_ack  = 1'b1;
      busw.imem_data = 32'h0020_81B3;
      @(negedge clk);
      busw.imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("wrap_req1",    {31'd0, busw.imem_req}, 32'd1);
      chk("wrap_addr1",   busw.imem_addr, 32'h0000_0000);
      chk("wrap_pc",      busw.pc, 32'h0000_0000);
      chk("wrap_instret", busw.instret, 32'd1);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the integer core. It fetches one instruction at a time over a req/ack instruction-memory handshake and holds it in an instruction register. It then drives the active-low enables of the register-register and register-immediate ALU execution units and sequences register-file writeback. It sits between instruction memory and the execution units and owns the program counter.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width; only 32 is supported.

- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_data valid in the same cycle.
- imem_data  in  XLEN  fetched instruction word.
- instruction  out  XLEN  instruction register (IR), broadcast to execution units.
- alu_reg_en_n  out  1  active-low enable for the R-type (OP) execution unit.
- alu_imm_en_n  out  1  active-low enable for the I-type (OP-IMM) execution unit.
- rf_we  out  1  register-file write strobe for the enabled unit's result.
- pc  out  XLEN  current program counter.
- instret  out  32  retired-instruction counter.
- illegal  out  1  sticky flag for an unsupported opcode.

## Operation

- States: IDLE, FETCH, DECODE, EXEC_A, EXEC_B, TRAP.
- IDLE: entered on reset; moves unconditionally to FETCH on the next edge.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On an edge with imem_ack=1: IR<=imem_data, then go to DECODE.
  - Otherwise remain in FETCH with req held.
- DECODE: opcode is IR[6:0].
  - 7'b0110011 goes to EXEC_A with the unit select = reg.
  - 7'b0010011 goes to EXEC_A with the unit select = imm.
  - Any other value: illegal<=1, then go to TRAP.
- EXEC_A: the selected unit's en_n=0, the other =1. The unit latches its register selects on this edge.
- EXEC_B:
  - Selected en_n held 0.
  - rf_we=1 if IR[11:7]!=0; rf_we=0 when rd is x0.
  - On exit: pc<=pc+4, instret<=instret+1, then go to FETCH.
- TRAP: all enables=1, imem_req=0, rf_we=0. Terminal until rst_n is asserted.
- Arithmetic:
  - pc+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
  - instret wraps from 32'hFFFF_FFFF to 0.
- Outputs are decoded from the registered state, with no combinational path from imem_ack to any output.
- imem_ack outside FETCH is ignored. IR only changes in FETCH.

## Timing

- Reset values (applied immediately on rst_n=0, any state):
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, instruction=0.
  - alu_reg_en_n=1, alu_imm_en_n=1, rf_we=0.
  - instret=0, illegal=0.
- Reset asserted mid-fetch or mid-execute:
  - The in-flight instruction is abandoned; no write and no instret increment.
  - Any later ack is ignored until FETCH is re-entered.
- Latency with zero-wait memory (ack in the first FETCH cycle) is 4 cycles per instruction: FETCH, DECODE, EXEC_A, EXEC_B.
- Each memory wait cycle adds 1 cycle.
- The first imem_req rises 1 cycle after rst_n deasserts (IDLE cycle).
- Enable is low for exactly 2 consecutive cycles per instruction. rf_we is high for exactly 1 cycle, coincident with the second of those cycles.
- The enables never go low simultaneously; they are never low outside EXEC_A/EXEC_B.
- pc and instret update on the edge leaving EXEC_B and are visible in the following FETCH cycle.

## Test plan

- Reset with RESET_PC=32'h100 and zero-wait ack; feed add x3,x1,x2 (32'h002081B3).
  - Expect: req at cycle 1, addr 32'h100.
  - alu_reg_en_n low in cycles 3–4; rf_we high in cycle 4 only.
  - Next fetch at 32'h104; instret=1.
- addi x5,x0,7 (32'h00700293) with ack delayed 3 cycles.
  - Expect: req held 4 cycles and the address stable.
  - alu_imm_en_n low for 2 cycles with alu_reg_en_n=1.
  - Total of 7 cycles to the next req.
- add x0,x1,x2 (32'h00208033).
  - Expect: enables sequence normally, rf_we never asserted, pc advances by 4, instret increments.
- Load opcode word 32'h00002003.
  - Expect: illegal=1 after DECODE.
  - Then permanently imem_req=0, enables=1, pc unchanged, instret unchanged.
  - After rst_n pulse, illegal=0.
- RESET_PC=32'hFFFF_FFFC, one OP instruction.
  - Expect: next imem_addr=32'h0000_0000.
- Assert rst_n=0 asynchronously during EXEC_B.
  - Expect: rf_we and enables return to reset values within the same cycle (no clock edge needed); instret stays 0.
